// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller: access sizes,
// controller states, byte-lane strobes, store lane replication, load
// extension and the alignment rule.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } dmem_state_t;

  // Halves must sit on even offsets, words on offset 0; the reserved size
  // is always rejected.
  function automatic logic is_misaligned(size_t size, logic [1:0] off);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = off[0];
      SIZE_W:  bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte-lane enables for an access of the given size at lane offset off.
  function automatic logic [3:0] strobe_of(size_t size, logic [1:0] off);
    logic [3:0] stb;
    case (size)
      SIZE_B:  stb = 4'b0001 << off;
      SIZE_H:  stb = 4'b0011 << off;
      SIZE_W:  stb = 4'b1111;
      default: stb = 4'b0000;
    endcase
    return stb;
  endfunction

  // Right-aligned store data copied onto every lane so the strobe alone
  // picks which lanes land in the array.
  function automatic logic [31:0] replicate_wdata(size_t size, logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SIZE_B:  lanes = {4{wdata[7:0]}};
      SIZE_H:  lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  // Pick the addressed lane(s) out of the word and sign/zero extend.
  // Word loads ignore the unsigned flag.
  function automatic logic [31:0] extend_load(logic [31:0] word, size_t size,
                                               logic [1:0] off, logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SIZE_H:  r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
      SIZE_W:  r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between a load/store unit (master) and the
// data-memory controller (slave). Requests and responses each use a
// valid/ready handshake.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_byte_ram.sv
// DEPTH x 32 storage with per-byte write enables.
// Writes land on the rising clock edge; reads are combinational.
// Contents are never reset.
module dmem_byte_ram #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-3:0] addr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [31:0] mem_q [DEPTH];

  // Byte-lane write: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];
endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data-memory controller with LATENCY wait states.
// Response valid LATENCY+2 cycles from the accept cycle; one txn per LATENCY+3.
// req_ready drops from accept until the response is consumed; rsp held until rsp_ready.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int    ADDR_W    = 8,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input logic         clk,
  input logic         reset_n,
  dmem_ctrl_if.slave  bus
);
  localparam logic [2:0] LAT_CNT = 3'(LATENCY);

  dmem_state_t       state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  size_t             size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]  off;
  logic        misaligned;
  logic        ram_we;
  logic [31:0] ram_rdata;

  assign off        = addr_q[1:0];
  assign misaligned = is_misaligned(size_q, off);

  // The array is only written in ACCESS; a reset in the same cycle wins.
  assign ram_we = (state_q == ACCESS) && reset_n && wr_q && !misaligned;

  dmem_byte_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q[ADDR_W-1:2]),
    .wstrb (strobe_of(size_q, off)),
    .wdata (replicate_wdata(size_q, wdata_q)),
    .rdata (ram_rdata)
  );

  // Next-state and next-output logic for the IDLE/WAIT/ACCESS/RESP sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          wr_d        = bus.req_write;
          addr_d      = bus.req_addr;
          size_d      = size_t'(bus.req_size);
          uns_d       = bus.req_unsigned;
          wdata_d     = bus.req_wdata;
          cnt_d       = LAT_CNT;
          req_ready_d = 1'b0;
          state_d     = (LAT_CNT == 3'd0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = ACCESS;
      end
      ACCESS: begin
        rsp_err_d   = misaligned;
        rsp_rdata_d = (!wr_q && !misaligned)
                    ? extend_load(ram_rdata, size_q, off, uns_q) : 32'h0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= SIZE_B;
      uns_q       <= 1'b0;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: stores/loads of every size, misalignment,
// response backpressure and reset in the middle of a store.
// LAT selects the wait-state count; expected latency is LAT+2 cycles.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  parameter int LAT = 1;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_W(8)) bus ();

  dmem_ctrl #(
    .ADDR_W    (8),
    .LATENCY   (LAT),
    .INIT_FILE ("")
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge, then scramble the request inputs after
  // the accept edge. Waits (bounded) for the response, holds rsp_ready low
  // for 'hold' cycles checking stability, then consumes the response.
  task automatic txn(input string tag, input logic wr, input logic [7:0] addr,
                     input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                     input int hold, output logic [31:0] rdata, output logic err);
    int lat;
    @(negedge clk);
    chk({tag, ".req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_write    = ~wr;
    bus.req_addr     = ~addr;
    bus.req_size     = ~size;
    bus.req_unsigned = ~uns;
    bus.req_wdata    = ~wdata;
    lat = 0;
    rdata = 32'hx;
    err = 1'bx;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid === 1'b1) break;
      chk({tag, ".req_ready_busy"}, 32'(bus.req_ready), 32'd0);
    end
    chk({tag, ".latency"}, 32'(lat), 32'(LAT + 2));
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, bus.rsp_rdata, rdata);
      chk({tag, ".hold_err"},   32'(bus.rsp_err), 32'(err));
      chk({tag, ".hold_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, ".rsp_cleared"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".ready_again"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    reset_n          = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = 8'h00;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst.rsp_err",   32'(bus.rsp_err), 32'd0);
    reset_n = 1'b1;

    // Word store/load round trip.
    txn("st_w10", 1'b1, 8'h10, SIZE_W, 1'b0, 32'hDEADBEEF, 0, rd, er);
    chk("st_w10.rdata", rd, 32'h0);
    chk("st_w10.err", 32'(er), 32'd0);
    txn("ld_w10", 1'b0, 8'h10, SIZE_W, 1'b0, 32'h0, 0, rd, er);
    chk("ld_w10.rdata", rd, 32'hDEADBEEF);
    chk("ld_w10.err", 32'(er), 32'd0);

    // Byte store into lane 2, then sub-word loads.
    txn("st_b12", 1'b1, 8'h12, SIZE_B, 1'b0, 32'h0000005A, 0, rd, er);
    chk("st_b12.err", 32'(er), 32'd0);
    txn("ld_sb13", 1'b0, 8'h13, SIZE_B, 1'b0, 32'h0, 0, rd, er);
    chk("ld_sb13.rdata", rd, 32'hFFFFFFDE);
    txn("ld_uh12", 1'b0, 8'h12, SIZE_H, 1'b1, 32'h0, 0, rd, er);
    chk("ld_uh12.rdata", rd, 32'h0000DE5A);
    txn("ld_ub10", 1'b0, 8'h10, SIZE_B, 1'b1, 32'h0, 0, rd, er);
    chk("ld_ub10.rdata", rd, 32'h000000EF);
    txn("ld_sh10", 1'b0, 8'h10, SIZE_H, 1'b0, 32'h0, 0, rd, er);
    chk("ld_sh10.rdata", rd, 32'hFFFFBEEF);
    txn("ld_w10b", 1'b0, 8'h10, SIZE_W, 1'b1, 32'h0, 0, rd, er);
    chk("ld_w10b.rdata", rd, 32'hDE5ABEEF);

    // Misaligned and reserved-size requests.
    txn("ld_w11", 1'b0, 8'h11, SIZE_W, 1'b0, 32'h0, 0, rd, er);
    chk("ld_w11.rdata", rd, 32'h0);
    chk("ld_w11.err", 32'(er), 32'd1);
    txn("st_h13", 1'b1, 8'h13, SIZE_H, 1'b0, 32'h0000FFFF, 0, rd, er);
    chk("st_h13.rdata", rd, 32'h0);
    chk("st_h13.err", 32'(er), 32'd1);
    txn("ld_rsv00", 1'b0, 8'h00, SIZE_RSV, 1'b0, 32'h0, 0, rd, er);
    chk("ld_rsv00.rdata", rd, 32'h0);
    chk("ld_rsv00.err", 32'(er), 32'd1);
    txn("ld_w10c", 1'b0, 8'h10, SIZE_W, 1'b0, 32'h0, 0, rd, er);
    chk("ld_w10c.rdata", rd, 32'hDE5ABEEF);
    chk("ld_w10c.err", 32'(er), 32'd0);

    // Response held under backpressure for 5 cycles.
    txn("hold_ld", 1'b0, 8'h10, SIZE_B, 1'b0, 32'h0, 5, rd, er);
    chk("hold_ld.rdata", rd, 32'hFFFFFFEF);

    // Reset in the middle of a store must discard it.
    txn("st_w20", 1'b1, 8'h20, SIZE_W, 1'b0, 32'hCAFEF00D, 0, rd, er);
    txn("ld_w20", 1'b0, 8'h20, SIZE_W, 1'b0, 32'h0, 0, rd, er);
    chk("ld_w20.rdata", rd, 32'hCAFEF00D);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 8'h20;
    bus.req_size  = SIZE_W;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("midrst.busy", 32'(bus.req_ready), 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst.req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst.rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("midrst.rsp_err",   32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    txn("ld_w20b", 1'b0, 8'h20, SIZE_W, 1'b0, 32'h0, 0, rd, er);
    chk("ld_w20b.rdata", rd, 32'hCAFEF00D);
    chk("ld_w20b.err", 32'(er), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
